// File: rtl/multi_ch_sync_fifo.sv
// Single-clock multi-channel FIFO. NUM_CH independent queues share one storage
// array addressed by {channel, pointer}. One write and one read are accepted per
// cycle. The read data path is registered, so it has one cycle of latency.
// Flags are decoded from registered counts only.
module multi_ch_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_CH     = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [$clog2(NUM_CH)-1:0]           wr_ch,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                rd_en,
    input  logic [$clog2(NUM_CH)-1:0]           rd_ch,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_valid,
    output logic [$clog2(NUM_CH)-1:0]           rd_data_ch,
    input  logic                                flush,
    input  logic [$clog2(NUM_CH)-1:0]           flush_ch,
    input  logic                                err_clr,
    output logic [NUM_CH-1:0]                   full,
    output logic [NUM_CH-1:0]                   empty,
    output logic [NUM_CH-1:0]                   almost_full,
    output logic [NUM_CH-1:0]                   almost_empty,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]    count,
    output logic [NUM_CH-1:0]                   overflow,
    output logic [NUM_CH-1:0]                   underflow
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int CW     = ADDR_WIDTH + 1;
    localparam int MEM_AW = CH_W + ADDR_WIDTH;

    logic [CW-1:0]         wr_ptr_q [NUM_CH];
    logic [CW-1:0]         wr_ptr_d [NUM_CH];
    logic [CW-1:0]         rd_ptr_q [NUM_CH];
    logic [CW-1:0]         rd_ptr_d [NUM_CH];
    logic [CW-1:0]         cnt_q    [NUM_CH];
    logic [CW-1:0]         cnt_d    [NUM_CH];
    logic [NUM_CH-1:0]     ovf_q, ovf_d;
    logic [NUM_CH-1:0]     unf_q, unf_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CH_W-1:0]       rd_data_ch_q, rd_data_ch_d;

    logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];

    logic                  wr_flushed, wr_full, wr_acc, wr_rej;
    logic                  rd_flushed, rd_empty, rd_acc, rd_rej;
    logic [MEM_AW-1:0]     wr_addr, rd_addr;

    // Accept/reject decisions from pre-edge counts; flush silently drops same-channel requests.
    always_comb begin
        wr_flushed = flush && (flush_ch == wr_ch);
        rd_flushed = flush && (flush_ch == rd_ch);
        wr_full    = (cnt_q[wr_ch] == CW'(DEPTH));
        rd_empty   = (cnt_q[rd_ch] == '0);
        wr_acc     = wr_en && !wr_full && !wr_flushed;
        wr_rej     = wr_en &&  wr_full && !wr_flushed;
        rd_acc     = rd_en && !rd_empty && !rd_flushed;
        rd_rej     = rd_en &&  rd_empty && !rd_flushed;
        wr_addr    = {wr_ch, wr_ptr_q[wr_ch][ADDR_WIDTH-1:0]};
        rd_addr    = {rd_ch, rd_ptr_q[rd_ch][ADDR_WIDTH-1:0]};
    end

    // Per-channel pointer and count update; a flush overrides any traffic on its channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (flush && (flush_ch == CH_W'(i))) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end else begin
                if (wr_acc && (wr_ch == CH_W'(i)))
                    wr_ptr_d[i] = wr_ptr_q[i] + CW'(1);
                if (rd_acc && (rd_ch == CH_W'(i)))
                    rd_ptr_d[i] = rd_ptr_q[i] + CW'(1);
                if ((wr_acc && (wr_ch == CH_W'(i))) && !(rd_acc && (rd_ch == CH_W'(i))))
                    cnt_d[i] = cnt_q[i] + CW'(1);
                else if (!(wr_acc && (wr_ch == CH_W'(i))) && (rd_acc && (rd_ch == CH_W'(i))))
                    cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // Sticky errors: clear first so that a same-cycle new error still sets its bit.
    always_comb begin
        ovf_d = err_clr ? '0 : ovf_q;
        unf_d = err_clr ? '0 : unf_q;
        if (wr_rej)
            ovf_d[wr_ch] = 1'b1;
        if (rd_rej)
            unf_d[rd_ch] = 1'b1;
    end

    // Registered read port; data and channel hold their last value when idle.
    always_comb begin
        rd_valid_d   = rd_acc;
        rd_data_d    = rd_data_q;
        rd_data_ch_d = rd_data_ch_q;
        if (rd_acc) begin
            rd_data_d    = mem_q[rd_addr];
            rd_data_ch_d = rd_ch;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            ovf_q        <= '0;
            unf_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_data_ch_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_data_ch_q <= rd_data_ch_d;
        end
    end

    // Shared storage; contents are not cleared by reset, pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc)
            mem_q[wr_addr] <= wr_data;
    end

    // Flag decode and count packing from registered counts.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]         = (cnt_q[i] == CW'(DEPTH));
            empty[i]        = (cnt_q[i] == '0);
            almost_full[i]  = (cnt_q[i] >= CW'(AF_LEVEL));
            almost_empty[i] = (cnt_q[i] <= CW'(AE_LEVEL));
            count[i*CW +: CW] = cnt_q[i];
        end
    end

    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_data_ch = rd_data_ch_q;

endmodule

// File: tb/tb_multi_ch_sync_fifo.sv
// Directed bench for multi_ch_sync_fifo with 4 channels of depth 8.
module tb_multi_ch_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_ch;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [1:0] rd_data_ch;
    logic       flush;
    logic [1:0] flush_ch;
    logic       err_clr;
    logic [3:0] full, empty, almost_full, almost_empty, overflow, underflow;
    logic [15:0] count;

    int passed = 0;
    int total  = 0;

    multi_ch_sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_CH(4), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_data_ch(rd_data_ch),
        .flush(flush), .flush_ch(flush_ch), .err_clr(err_clr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] cnt(input int ch);
        return count[ch*4 +: 4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); wr_ch = 0; rd_ch = 0; wr_data = 0; flush_ch = 0;
        step();
        rst_n = 1'b1;
        step();
        total++; if (empty !== 4'b1111) $display("FAIL reset_empty got %b exp 1111", empty); else passed++;
        total++; if (full !== 4'b0000) $display("FAIL reset_full got %b exp 0000", full); else passed++;
        total++; if (count !== 16'h0000) $display("FAIL reset_count got %h exp 0000", count); else passed++;
        total++; if (almost_empty !== 4'b1111) $display("FAIL reset_ae got %b exp 1111", almost_empty); else passed++;
        total++; if (almost_full !== 4'b0000) $display("FAIL reset_af got %b exp 0000", almost_full); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else passed++;
        total++; if ({overflow, underflow} !== 8'h00) $display("FAIL reset_err got %h exp 00", {overflow, underflow}); else passed++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_ch = 2; wr_data = 8'h10 + 8'(i);
            step();
            total++; if (almost_full[2] !== (i + 1 >= 6)) $display("FAIL fill_af i=%0d got %b exp %b", i, almost_full[2], (i + 1 >= 6)); else passed++;
            total++; if (almost_empty[2] !== (i + 1 <= 2)) $display("FAIL fill_ae i=%0d got %b exp %b", i, almost_empty[2], (i + 1 <= 2)); else passed++;
        end
        total++; if (full !== 4'b0100) $display("FAIL fill_full got %b exp 0100", full); else passed++;
        total++; if (cnt(2) !== 4'd8) $display("FAIL fill_count2 got %0d exp 8", cnt(2)); else passed++;
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        total++; if (overflow !== 4'b0100) $display("FAIL fill_overflow got %b exp 0100", overflow); else passed++;
        total++; if (cnt(2) !== 4'd8) $display("FAIL fill_count_after_ovf got %0d exp 8", cnt(2)); else passed++;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_ch = 2;
            step();
            total++; if (rd_valid !== 1'b1) $display("FAIL drain_valid i=%0d got %b exp 1", i, rd_valid); else passed++;
            total++; if (rd_data !== 8'h10 + 8'(i)) $display("FAIL drain_data i=%0d got %h exp %h", i, rd_data, 8'h10 + 8'(i)); else passed++;
            total++; if (rd_data_ch !== 2'd2) $display("FAIL drain_ch i=%0d got %0d exp 2", i, rd_data_ch); else passed++;
            total++; if (almost_full[2] !== (7 - i >= 6)) $display("FAIL drain_af i=%0d got %b exp %b", i, almost_full[2], (7 - i >= 6)); else passed++;
        end
        rd_en = 1'b0;
        step();
        total++; if (rd_valid !== 1'b0) $display("FAIL drain_valid_drop got %b exp 0", rd_valid); else passed++;
        total++; if (rd_data !== 8'h17) $display("FAIL drain_hold got %h exp 17", rd_data); else passed++;
        total++; if (empty !== 4'b1111) $display("FAIL drain_empty got %b exp 1111", empty); else passed++;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if (overflow !== 4'b0000) $display("FAIL errclr_plain got %b exp 0000", overflow); else passed++;
    endtask

    task automatic test_interleave();
        logic [7:0] exp_q [8];
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_ch = 0; wr_data = 8'hA0 + 8'(i);
            step();
            wr_ch = 3; wr_data = 8'hB0 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        total++; if (cnt(0) !== 4'd4 || cnt(3) !== 4'd4) $display("FAIL inter_counts got %0d/%0d exp 4/4", cnt(0), cnt(3)); else passed++;
        total++; if (cnt(1) !== 4'd0 || cnt(2) !== 4'd0) $display("FAIL inter_other got %0d/%0d exp 0/0", cnt(1), cnt(2)); else passed++;
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_ch = (i < 4) ? 2'd3 : 2'd0;
            step();
            total++; if (rd_valid !== 1'b1 || rd_data !== exp_q[i] || rd_data_ch !== rd_ch) $display("FAIL inter_read i=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d", i, rd_valid, rd_data, rd_data_ch, exp_q[i], rd_ch); else passed++;
        end
        rd_en = 1'b0;
        step();
        total++; if (empty !== 4'b1111) $display("FAIL inter_empty got %b exp 1111", empty); else passed++;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_ch = 1; wr_data = 8'h20 + 8'(i);
            step();
        end
        wr_data = 8'h55; rd_en = 1'b1; rd_ch = 1;
        step();
        wr_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h20) $display("FAIL simfull_read got v=%b d=%h exp v=1 d=20", rd_valid, rd_data); else passed++;
        total++; if (overflow !== 4'b0010) $display("FAIL simfull_ovf got %b exp 0010", overflow); else passed++;
        total++; if (cnt(1) !== 4'd7) $display("FAIL simfull_count got %0d exp 7", cnt(1)); else passed++;
        for (int i = 1; i < 8; i++) begin
            step();
            total++; if (rd_data !== 8'h20 + 8'(i)) $display("FAIL simfull_drain i=%0d got %h exp %h", i, rd_data, 8'h20 + 8'(i)); else passed++;
        end
        rd_en = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if (empty[1] !== 1'b1) $display("FAIL simfull_empty got %b exp 1", empty[1]); else passed++;
        wr_en = 1'b1; wr_ch = 1; wr_data = 8'h66; rd_en = 1'b1; rd_ch = 1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (rd_valid !== 1'b0) $display("FAIL simempty_valid got %b exp 0", rd_valid); else passed++;
        total++; if (underflow !== 4'b0010) $display("FAIL simempty_unf got %b exp 0010", underflow); else passed++;
        total++; if (cnt(1) !== 4'd1) $display("FAIL simempty_count got %0d exp 1", cnt(1)); else passed++;
        rd_en = 1'b1; err_clr = 1'b1;
        step();
        rd_en = 1'b0; err_clr = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h66) $display("FAIL simempty_read got v=%b d=%h exp v=1 d=66", rd_valid, rd_data); else passed++;
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_ch = 0; wr_data = 8'hC0 + 8'(i);
            step();
        end
        total++; if (cnt(0) !== 4'd5) $display("FAIL flush_pre_count got %0d exp 5", cnt(0)); else passed++;
        flush = 1'b1; flush_ch = 0; wr_ch = 0; wr_data = 8'hEE; rd_en = 1'b1; rd_ch = 0;
        step();
        total++; if (cnt(0) !== 4'd0 || empty[0] !== 1'b1) $display("FAIL flush_count got %0d empty=%b exp 0 empty=1", cnt(0), empty[0]); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", rd_valid); else passed++;
        total++; if ({overflow, underflow} !== 8'h00) $display("FAIL flush_err got %h exp 00", {overflow, underflow}); else passed++;
        rd_en = 1'b0; wr_ch = 1; wr_data = 8'h77;
        step();
        flush = 1'b0; wr_en = 1'b0;
        total++; if (cnt(1) !== 4'd1 || cnt(0) !== 4'd0) $display("FAIL flush_other got %0d/%0d exp 1/0", cnt(1), cnt(0)); else passed++;
        rd_en = 1'b1; rd_ch = 1;
        step();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || rd_data_ch !== 2'd1) $display("FAIL flush_other_read got v=%b d=%h ch=%0d exp v=1 d=77 ch=1", rd_valid, rd_data, rd_data_ch); else passed++;
    endtask

    task automatic test_err_clr();
        rd_en = 1'b1; rd_ch = 0;
        step();
        rd_ch = 2;
        step();
        wr_en = 1'b1; wr_ch = 1; wr_data = 8'h01;
        for (int i = 0; i < 8; i++) step();
        wr_en = 1'b1;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        total++; if (underflow !== 4'b0101 || overflow !== 4'b0010) $display("FAIL err_setup got u=%b o=%b exp u=0101 o=0010", underflow, overflow); else passed++;
        err_clr = 1'b1; rd_en = 1'b1; rd_ch = 3;
        step();
        err_clr = 1'b0; rd_en = 1'b0;
        total++; if (underflow !== 4'b1000) $display("FAIL errclr_unf got %b exp 1000", underflow); else passed++;
        total++; if (overflow !== 4'b0000) $display("FAIL errclr_ovf got %b exp 0000", overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_ch = 2; wr_data = 8'hD0 + 8'(i);
            step();
        end
        wr_en = 1'b0; rd_en = 1'b1; rd_ch = 2;
        step();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'hD0) $display("FAIL rstmid_pre got v=%b d=%h exp v=1 d=D0", rd_valid, rd_data); else passed++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (count !== 16'h0000 || empty !== 4'b1111 || full !== 4'b0000) $display("FAIL rstmid_occ got c=%h e=%b f=%b exp c=0000 e=1111 f=0000", count, empty, full); else passed++;
        total++; if (almost_empty !== 4'b1111 || almost_full !== 4'b0000) $display("FAIL rstmid_almost got ae=%b af=%b exp ae=1111 af=0000", almost_empty, almost_full); else passed++;
        total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_data_ch !== 2'd0) $display("FAIL rstmid_rd got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", rd_valid, rd_data, rd_data_ch); else passed++;
        total++; if ({overflow, underflow} !== 8'h00) $display("FAIL rstmid_err got %h exp 00", {overflow, underflow}); else passed++;
        wr_en = 1'b1; wr_ch = 2; wr_data = 8'h99;
        step();
        wr_en = 1'b0; rd_en = 1'b1; rd_ch = 2;
        step();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h99) $display("FAIL rstmid_fresh got v=%b d=%h exp v=1 d=99", rd_valid, rd_data); else passed++;
        total++; if (empty[2] !== 1'b1) $display("FAIL rstmid_empty got %b exp 1", empty[2]); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_interleave();
        test_simultaneous();
        test_flush();
        test_err_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
